// File: rtl/serial_tx_pkg.sv
// Shared types for the serial transmit shifter: FSM states, SCON mode encodings, counter sizing.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_NINTH = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE0_SYNC   = 2'd0,
    MODE1_UART8  = 2'd1,
    MODE2_UART9F = 2'd2,
    MODE3_UART9V = 2'd3
  } mode_e;

  function automatic int bitcnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_hold_buffer.sv
// One-entry {data,tb8,mode} holding register; a request while full is dropped and flagged with a
// one-cycle overrun pulse on the following cycle, contents untouched.
module serial_tx_hold_buffer
  import serial_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              pop,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_tb8,
  input  mode_e             req_mode,
  output logic              full,
  output logic [DATA_W-1:0] held_data,
  output logic              held_tb8,
  output mode_e             held_mode,
  output logic              overrun
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full      <= 1'b0;
      overrun   <= 1'b0;
      held_data <= '0;
      held_tb8  <= 1'b0;
      held_mode <= MODE0_SYNC;
    end else begin
      overrun <= req && full;
      if (req && !full) begin
        full      <= 1'b1;
        held_data <= req_data;
        held_tb8  <= req_tb8;
        held_mode <= req_mode;
      end else if (pop) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_tx_frame_shifter.sv
// Serial transmit shifter (mode 0 sync, modes 1-3 async) with one-entry holding buffer; tx registered.
// SERIAL_TX_PARITY_EN: modes 2/3 send even data parity as 9th bit, tb8=1 selects odd.
module serial_tx_frame_shifter
  import serial_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              serial_clock_i,
  input  logic              serial_reset_i,
  input  logic [DATA_W-1:0] serial_data_sbuf_i,
  input  logic              serial_start_shifter_reg_i,
  input  logic              serial_shift_i,
  input  logic              serial_scon3_tb8_i,
  input  logic [1:0]        serial_mode_i,
  output logic              serial_data_tx_o,
  output logic              serial_end_bit_o,
  output logic              serial_busy_o,
  output logic              serial_overrun_o
);

  localparam int CNT_W = bitcnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_e            state;
  mode_e             mode_q;
  logic [DATA_W-1:0] shreg;
  logic              ninth;
  logic [CNT_W-1:0]  cnt;
  logic              stop_cnt;
  logic              tx_q;
  logic              end_q;

  logic              hb_full;
  logic [DATA_W-1:0] hb_data;
  logic              hb_tb8;
  mode_e             hb_mode;
  logic              hb_overrun;

  logic              frame_done;
  logic              start_direct;
  logic              hold_req;
  logic              pop;
  logic              load;
  logic [DATA_W-1:0] ld_data;
  logic              ld_tb8;
  mode_e             ld_mode;
  logic              ld_ninth;

  always_comb begin
    frame_done = 1'b0;
    if (serial_shift_i) begin
      case (state)
        ST_DATA: frame_done = (cnt == LAST_BIT) && (mode_q == MODE0_SYNC);
        ST_STOP: frame_done = (stop_cnt == LAST_STOP);
        default: frame_done = 1'b0;
      endcase
    end
    // A start on the final tick bypasses the buffer only when nothing is already queued.
    start_direct = serial_start_shifter_reg_i && ((state == ST_IDLE) || (frame_done && !hb_full));
    hold_req     = serial_start_shifter_reg_i && !start_direct;
    pop          = frame_done && hb_full;
    load         = start_direct || pop;
    ld_data      = pop ? hb_data : serial_data_sbuf_i;
    ld_tb8       = pop ? hb_tb8  : serial_scon3_tb8_i;
    ld_mode      = pop ? hb_mode : mode_e'(serial_mode_i);
`ifdef SERIAL_TX_PARITY_EN
    ld_ninth     = (^ld_data) ^ ld_tb8;
`else
    ld_ninth     = ld_tb8;
`endif
  end

  serial_tx_hold_buffer #(.DATA_W(DATA_W)) u_hold (
    .clk       (serial_clock_i),
    .reset     (serial_reset_i),
    .req       (hold_req),
    .pop       (pop),
    .req_data  (serial_data_sbuf_i),
    .req_tb8   (serial_scon3_tb8_i),
    .req_mode  (mode_e'(serial_mode_i)),
    .full      (hb_full),
    .held_data (hb_data),
    .held_tb8  (hb_tb8),
    .held_mode (hb_mode),
    .overrun   (hb_overrun)
  );

  always_ff @(posedge serial_clock_i) begin
    if (serial_reset_i) begin
      state    <= ST_IDLE;
      mode_q   <= MODE0_SYNC;
      shreg    <= '0;
      ninth    <= 1'b0;
      cnt      <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      end_q    <= 1'b0;
    end else begin
      end_q <= frame_done;
      if (load) begin
        shreg    <= ld_data;
        ninth    <= ld_ninth;
        mode_q   <= ld_mode;
        cnt      <= '0;
        stop_cnt <= 1'b0;
        if (ld_mode == MODE0_SYNC) begin
          state <= ST_DATA;
          tx_q  <= ld_data[0];
        end else begin
          state <= ST_START;
          tx_q  <= 1'b0;
        end
      end else if (frame_done) begin
        state <= ST_IDLE;
        tx_q  <= 1'b1;
      end else if (serial_shift_i) begin
        case (state)
          ST_START: begin
            state <= ST_DATA;
            tx_q  <= shreg[0];
          end
          ST_DATA: begin
            if (cnt == LAST_BIT) begin
              if (mode_q == MODE1_UART8) begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end else begin
                state <= ST_NINTH;
                tx_q  <= ninth;
              end
            end else begin
              cnt   <= cnt + 1'b1;
              shreg <= {1'b0, shreg[DATA_W-1:1]};
              tx_q  <= shreg[1];
            end
          end
          ST_NINTH: begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
          ST_STOP: stop_cnt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign serial_data_tx_o = tx_q;
  assign serial_end_bit_o = end_q;
  assign serial_busy_o    = (state != ST_IDLE) || hb_full;
  assign serial_overrun_o = hb_overrun;

endmodule

// File: tb/tb_serial_tx_frame_shifter.sv
// Directed bench for serial_tx_frame_shifter: framing per mode, buffering, overrun, reset abort.
module tb_serial_tx_frame_shifter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sbuf = 8'h00;
  logic       start = 1'b0;
  logic       shift = 1'b0;
  logic       tb8 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       tx;
  logic       end_bit;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_tx_frame_shifter #(.DATA_W(8), .STOP_BITS(1)) dut (
    .serial_clock_i             (clk),
    .serial_reset_i             (reset),
    .serial_data_sbuf_i         (sbuf),
    .serial_start_shifter_reg_i (start),
    .serial_shift_i             (shift),
    .serial_scon3_tb8_i         (tb8),
    .serial_mode_i              (mode),
    .serial_data_tx_o           (tx),
    .serial_end_bit_o           (end_bit),
    .serial_busy_o              (busy),
    .serial_overrun_o           (overrun)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; return at the next falling edge with outputs settled.
  task automatic step(input logic s, input logic t);
    start = s;
    shift = t;
    @(negedge clk);
    start = 1'b0;
    shift = 1'b0;
  endtask

  task automatic frame_bits(input string tag, input int n, input logic [15:0] bits,
                            input logic last_start, input logic tx_after, input logic busy_after);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s bit%0d tx", tag, i), 16'(tx), 16'(bits[i]));
      check($sformatf("%s bit%0d busy", tag, i), 16'(busy), 16'd1);
      step(1'b0, 1'b0);
      check($sformatf("%s bit%0d hold", tag, i), 16'({tx, end_bit}), 16'({bits[i], 1'b0}));
      step(last_start && (i == n - 1), 1'b1);
    end
    check({tag, " end"}, 16'(end_bit), 16'd1);
    check({tag, " tx_after"}, 16'(tx), 16'(tx_after));
    check({tag, " busy_after"}, 16'(busy), 16'(busy_after));
  endtask

  logic n_m2;
  logic n_m3;

  initial begin
`ifdef SERIAL_TX_PARITY_EN
    n_m2 = 1'b0;  // D5 has five ones -> even parity 1, tb8=1 inverts
    n_m3 = 1'b1;  // 07 has three ones -> even parity 1
`else
    n_m2 = 1'b1;
    n_m3 = 1'b0;
`endif
    @(negedge clk);
    step(1'b0, 1'b0);
    check("reset state", 16'({tx, end_bit, busy, overrun}), 16'b1000);
    reset = 1'b0;

    // Ticks while idle are ignored
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("idle ticks", 16'({tx, end_bit, busy}), 16'b100);

    // Mode 0, D5
    sbuf = 8'hD5; mode = 2'd0;
    step(1'b1, 1'b0);
    frame_bits("m0 d5", 8, 16'h00D5, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("m0 end one cycle", 16'(end_bit), 16'd0);

    // Mode 1, D5
    mode = 2'd1;
    step(1'b1, 1'b0);
    frame_bits("m1 d5", 10, 16'({1'b1, 8'hD5, 1'b0}), 1'b0, 1'b1, 1'b0);

    // Mode 2, D5, tb8=1; inputs changed mid-frame must not matter
    mode = 2'd2; tb8 = 1'b1;
    step(1'b1, 1'b0);
    mode = 2'd1; tb8 = 1'b0; sbuf = 8'h00;
    frame_bits("m2 d5", 11, 16'({1'b1, n_m2, 8'hD5, 1'b0}), 1'b0, 1'b1, 1'b0);

    // Mode 3, 07, tb8=0, start coincident with tick in idle
    mode = 2'd3; tb8 = 1'b0; sbuf = 8'h07;
    step(1'b1, 1'b1);
    frame_bits("m3 07", 11, 16'({1'b1, n_m3, 8'h07, 1'b0}), 1'b0, 1'b1, 1'b0);

    // Back-to-back via holding buffer, plus overrun on a third start
    mode = 2'd1; sbuf = 8'h55;
    step(1'b1, 1'b0);
    sbuf = 8'hAA;
    step(1'b1, 1'b0);
    check("b2b overrun quiet", 16'(overrun), 16'd0);
    sbuf = 8'h33; mode = 2'd0;
    step(1'b1, 1'b0);
    check("overrun pulse", 16'({overrun, busy}), 16'b11);
    step(1'b0, 1'b0);
    check("overrun one cycle", 16'(overrun), 16'd0);
    frame_bits("b2b 55", 10, 16'({1'b1, 8'h55, 1'b0}), 1'b0, 1'b0, 1'b1);
    frame_bits("b2b aa", 10, 16'({1'b1, 8'hAA, 1'b0}), 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("third word dropped", 16'({tx, busy, end_bit}), 16'b100);

    // Start on the final tick with buffer empty: direct load, no gap
    mode = 2'd0; sbuf = 8'h3C;
    step(1'b1, 1'b0);
    sbuf = 8'h81; mode = 2'd1;
    frame_bits("chain 3c", 8, 16'h003C, 1'b1, 1'b0, 1'b1);
    frame_bits("chain 81", 10, 16'({1'b1, 8'h81, 1'b0}), 1'b0, 1'b1, 1'b0);

    // Reset during DATA bit 3
    mode = 2'd0; sbuf = 8'hD5;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pre-reset bit3", 16'({tx, busy}), 16'b01);
    reset = 1'b1;
    step(1'b0, 1'b0);
    check("mid reset", 16'({tx, busy, end_bit, overrun}), 16'b1000);
    reset = 1'b0;
    step(1'b0, 1'b1);
    check("post reset idle", 16'({tx, busy, end_bit}), 16'b100);
    mode = 2'd1; sbuf = 8'hA5;
    step(1'b1, 1'b0);
    frame_bits("after reset a5", 10, 16'({1'b1, 8'hA5, 1'b0}), 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
